// File: rtl/mwc_pkg.sv
// Shared types for the memory-write checker: FSM states, failure codes and
// the expected-store table entry.
package mwc_pkg;

    // Table entries are stored at this fixed width; narrower XLEN values are
    // zero-extended on write and on compare, so the unused upper bits are
    // constant and get trimmed by synthesis.
    localparam int unsigned MWC_XLEN_MAX = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PASS = 2'd2,
        FAIL = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        FC_NONE    = 2'd0,
        FC_ADDR    = 2'd1,
        FC_DATA    = 2'd2,
        FC_TIMEOUT = 2'd3
    } fail_code_e;

    typedef struct packed {
        logic [MWC_XLEN_MAX-1:0] addr;
        logic [MWC_XLEN_MAX-1:0] data;
    } exp_entry_t;

    // Requested entry counts above the table depth are treated as the full table.
    function automatic int unsigned clamp_count(int unsigned req, int unsigned max_cnt);
        return (req > max_cnt) ? max_cnt : req;
    endfunction

endpackage

// File: rtl/mwc_exp_table.sv
// Expected-store table: entry storage, per-entry hit bits and the
// combinational lookups used by both ordered and unordered checking.
module mwc_exp_table
    import mwc_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NUM_EXP = 4,
    parameter int unsigned IDX_W   = 2,
    parameter int unsigned CNT_W   = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [XLEN-1:0]  wr_addr_i,
    input  logic [XLEN-1:0]  wr_data_i,
    input  logic             hit_clr_i,
    input  logic             hit_set_i,
    input  logic [IDX_W-1:0] hit_idx_i,
    input  logic [CNT_W-1:0] active_cnt_i,
    input  logic [IDX_W-1:0] ptr_i,
    input  logic [XLEN-1:0]  st_addr_i,
    input  logic [XLEN-1:0]  st_data_i,
    output logic             hit_valid_o,
    output logic [IDX_W-1:0] hit_idx_o,
    output logic             addr_match_o,
    output logic             ptr_addr_eq_o,
    output logic             ptr_data_eq_o
);

    exp_entry_t         entry_q [NUM_EXP];
    logic [NUM_EXP-1:0] hit_q;

    logic [MWC_XLEN_MAX-1:0] st_addr_x;
    logic [MWC_XLEN_MAX-1:0] st_data_x;

    assign st_addr_x = MWC_XLEN_MAX'(st_addr_i);
    assign st_data_x = MWC_XLEN_MAX'(st_data_i);

    // Entry writes (out-of-range indices dropped) and hit-bit tracking.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NUM_EXP; i++) begin
                entry_q[i] <= '0;
            end
            hit_q <= '0;
        end else begin
            if (wr_en_i && (int'(wr_idx_i) < int'(NUM_EXP))) begin
                entry_q[wr_idx_i].addr <= MWC_XLEN_MAX'(wr_addr_i);
                entry_q[wr_idx_i].data <= MWC_XLEN_MAX'(wr_data_i);
            end
            if (hit_clr_i) begin
                hit_q <= '0;
            end else if (hit_set_i) begin
                hit_q[hit_idx_i] <= 1'b1;
            end
        end
    end

    // Unordered search over unhit active entries; lowest matching index wins.
    always_comb begin
        hit_valid_o  = 1'b0;
        hit_idx_o    = '0;
        addr_match_o = 1'b0;
        for (int unsigned i = 0; i < NUM_EXP; i++) begin
            if (!hit_q[i] && (i < int'(active_cnt_i)) && (entry_q[i].addr == st_addr_x)) begin
                addr_match_o = 1'b1;
                if ((entry_q[i].data == st_data_x) && !hit_valid_o) begin
                    hit_valid_o = 1'b1;
                    hit_idx_o   = IDX_W'(i);
                end
            end
        end
    end

    // Ordered compare against the entry at the current pointer.
    always_comb begin
        ptr_addr_eq_o = 1'b0;
        ptr_data_eq_o = 1'b0;
        if (int'(ptr_i) < int'(NUM_EXP)) begin
            ptr_addr_eq_o = (entry_q[ptr_i].addr == st_addr_x);
            ptr_data_eq_o = (entry_q[ptr_i].data == st_data_x);
        end
    end

endmodule

// File: rtl/mem_write_checker.sv
// Self-checking monitor on the data-memory write port: matches observed
// stores against a programmed table, skips a scratch address, enforces a
// cycle timeout and captures the first failing store.
module mem_write_checker
    import mwc_pkg::*;
#(
    parameter int unsigned     XLEN           = 32,
    parameter int unsigned     NUM_EXP        = 4,
    parameter bit              ORDERED        = 1'b1,
    parameter bit              IGNORE_EN      = 1'b1,
    parameter logic [XLEN-1:0] IGNORE_ADDR    = XLEN'(96),
    parameter int unsigned     TIMEOUT_CYCLES = 10000
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic                                           exp_we,
    input  logic [((NUM_EXP > 1) ? $clog2(NUM_EXP) : 1)-1:0] exp_idx,
    input  logic [XLEN-1:0]                                exp_addr,
    input  logic [XLEN-1:0]                                exp_data,
    input  logic [$clog2(NUM_EXP+1)-1:0]                   exp_count,
    input  logic                                           start,
    input  logic                                           clear,
    input  logic                                           MemWrite,
    input  logic [XLEN-1:0]                                DataAdr,
    input  logic [XLEN-1:0]                                WriteData,
    output logic                                           busy,
    output logic                                           done,
    output logic                                           pass,
    output logic                                           fail,
    output logic [1:0]                                     fail_code,
    output logic [XLEN-1:0]                                fail_addr,
    output logic [XLEN-1:0]                                fail_data,
    output logic [$clog2(NUM_EXP+1)-1:0]                   match_count,
    output logic [15:0]                                    ignore_count,
    output logic [31:0]                                    cycle_count
);

    localparam int unsigned IDX_W = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1;
    localparam int unsigned CNT_W = $clog2(NUM_EXP + 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] match_q, match_d;
    logic [15:0]      ign_q, ign_d;
    logic [31:0]      cyc_q, cyc_d;
    fail_code_e       fc_q, fc_d;
    logic [XLEN-1:0]  faddr_q, faddr_d;
    logic [XLEN-1:0]  fdata_q, fdata_d;

    logic             tbl_clr;
    logic             tbl_set;
    logic [IDX_W-1:0] tbl_idx;
    logic             lk_hit;
    logic [IDX_W-1:0] lk_idx;
    logic             lk_addr_match;
    logic             ptr_addr_eq;
    logic             ptr_data_eq;

    logic             store_hit;
    logic             store_fail;
    fail_code_e       store_code;
    logic [CNT_W-1:0] cnt_start;

    assign cnt_start = CNT_W'(clamp_count(int'(exp_count), NUM_EXP));

    mwc_exp_table #(
        .XLEN    (XLEN),
        .NUM_EXP (NUM_EXP),
        .IDX_W   (IDX_W),
        .CNT_W   (CNT_W)
    ) u_table (
        .clk_i         (clk),
        .rst_ni        (reset),
        .wr_en_i       (exp_we && (state_q == IDLE)),
        .wr_idx_i      (exp_idx),
        .wr_addr_i     (exp_addr),
        .wr_data_i     (exp_data),
        .hit_clr_i     (tbl_clr),
        .hit_set_i     (tbl_set),
        .hit_idx_i     (tbl_idx),
        .active_cnt_i  (cnt_q),
        .ptr_i         (ptr_q),
        .st_addr_i     (DataAdr),
        .st_data_i     (WriteData),
        .hit_valid_o   (lk_hit),
        .hit_idx_o     (lk_idx),
        .addr_match_o  (lk_addr_match),
        .ptr_addr_eq_o (ptr_addr_eq),
        .ptr_data_eq_o (ptr_data_eq)
    );

    // State, counter and capture registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            match_q <= '0;
            ign_q   <= '0;
            cyc_q   <= '0;
            fc_q    <= FC_NONE;
            faddr_q <= '0;
            fdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            match_q <= match_d;
            ign_q   <= ign_d;
            cyc_q   <= cyc_d;
            fc_q    <= fc_d;
            faddr_q <= faddr_d;
            fdata_q <= fdata_d;
        end
    end

    // Next-state logic. A store decision takes priority over the timeout
    // on the same cycle: a completing hit passes and a bad store reports
    // its own code.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        match_d    = match_q;
        ign_d      = ign_q;
        cyc_d      = cyc_q;
        fc_d       = fc_q;
        faddr_d    = faddr_q;
        fdata_d    = fdata_q;
        tbl_clr    = 1'b0;
        tbl_set    = 1'b0;
        tbl_idx    = '0;
        store_hit  = 1'b0;
        store_fail = 1'b0;
        store_code = FC_NONE;

        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d   = cnt_start;
                    ptr_d   = '0;
                    match_d = '0;
                    ign_d   = '0;
                    cyc_d   = '0;
                    tbl_clr = 1'b1;
                    state_d = (cnt_start == '0) ? PASS : RUN;
                end
            end
            RUN: begin
                cyc_d = cyc_q + 32'd1;
                if (MemWrite) begin
                    if (IGNORE_EN && (DataAdr == IGNORE_ADDR)) begin
                        if (ign_q != 16'hFFFF) begin
                            ign_d = ign_q + 16'd1;
                        end
                    end else if (ORDERED) begin
                        if (ptr_addr_eq && ptr_data_eq) begin
                            store_hit = 1'b1;
                            tbl_idx   = ptr_q;
                        end else begin
                            store_fail = 1'b1;
                            store_code = ptr_addr_eq ? FC_DATA : FC_ADDR;
                        end
                    end else begin
                        if (lk_hit) begin
                            store_hit = 1'b1;
                            tbl_idx   = lk_idx;
                        end else begin
                            store_fail = 1'b1;
                            store_code = lk_addr_match ? FC_DATA : FC_ADDR;
                        end
                    end
                end

                if (store_hit) begin
                    tbl_set = 1'b1;
                    ptr_d   = ptr_q + IDX_W'(1);
                    match_d = match_q + CNT_W'(1);
                end

                if (store_fail) begin
                    state_d = FAIL;
                    fc_d    = store_code;
                    faddr_d = DataAdr;
                    fdata_d = WriteData;
                end else if (store_hit && ((match_q + CNT_W'(1)) == cnt_q)) begin
                    state_d = PASS;
                end else if (cyc_q == 32'(TIMEOUT_CYCLES - 1)) begin
                    state_d = FAIL;
                    fc_d    = FC_TIMEOUT;
                    faddr_d = '0;
                    fdata_d = '0;
                end
            end
            PASS, FAIL: begin
                if (clear) begin
                    state_d = IDLE;
                    fc_d    = FC_NONE;
                    faddr_d = '0;
                    fdata_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy         = (state_q == RUN);
    assign done         = (state_q == PASS) || (state_q == FAIL);
    assign pass         = (state_q == PASS);
    assign fail         = (state_q == FAIL);
    assign fail_code    = fc_q;
    assign fail_addr    = faddr_q;
    assign fail_data    = fdata_q;
    assign match_count  = match_q;
    assign ignore_count = ign_q;
    assign cycle_count  = cyc_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench: an ordered checker (short timeout) and an unordered checker
// share one stimulus set; each scenario checks the relevant instance.
module tb_mem_write_checker;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        exp_we = 1'b0;
    logic [1:0]  exp_idx = '0;
    logic [31:0] exp_addr = '0;
    logic [31:0] exp_data = '0;
    logic [2:0]  exp_count = '0;
    logic        start = 1'b0;
    logic        clear = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] DataAdr = '0;
    logic [31:0] WriteData = '0;

    logic        o_busy, o_done, o_pass, o_fail;
    logic [1:0]  o_fail_code;
    logic [31:0] o_fail_addr, o_fail_data;
    logic [2:0]  o_match_count;
    logic [15:0] o_ignore_count;
    logic [31:0] o_cycle_count;

    logic        u_busy, u_done, u_pass, u_fail;
    logic [1:0]  u_fail_code;
    logic [31:0] u_fail_addr, u_fail_data;
    logic [2:0]  u_match_count;
    logic [15:0] u_ignore_count;
    logic [31:0] u_cycle_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_write_checker #(
        .ORDERED        (1'b1),
        .TIMEOUT_CYCLES (20)
    ) u_ord (
        .clk(clk), .reset(reset), .exp_we(exp_we), .exp_idx(exp_idx),
        .exp_addr(exp_addr), .exp_data(exp_data), .exp_count(exp_count),
        .start(start), .clear(clear), .MemWrite(MemWrite), .DataAdr(DataAdr),
        .WriteData(WriteData), .busy(o_busy), .done(o_done), .pass(o_pass),
        .fail(o_fail), .fail_code(o_fail_code), .fail_addr(o_fail_addr),
        .fail_data(o_fail_data), .match_count(o_match_count),
        .ignore_count(o_ignore_count), .cycle_count(o_cycle_count)
    );

    mem_write_checker #(
        .ORDERED (1'b0)
    ) u_unord (
        .clk(clk), .reset(reset), .exp_we(exp_we), .exp_idx(exp_idx),
        .exp_addr(exp_addr), .exp_data(exp_data), .exp_count(exp_count),
        .start(start), .clear(clear), .MemWrite(MemWrite), .DataAdr(DataAdr),
        .WriteData(WriteData), .busy(u_busy), .done(u_done), .pass(u_pass),
        .fail(u_fail), .fail_code(u_fail_code), .fail_addr(u_fail_addr),
        .fail_data(u_fail_data), .match_count(u_match_count),
        .ignore_count(u_ignore_count), .cycle_count(u_cycle_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        reset = 1'b0;
        exp_we = 1'b0; start = 1'b0; clear = 1'b0; MemWrite = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    task automatic load(input int idx, input int a, input int d);
        exp_we = 1'b1; exp_idx = 2'(idx); exp_addr = 32'(a); exp_data = 32'(d);
        step();
        exp_we = 1'b0;
    endtask

    task automatic run(input int c);
        exp_count = 3'(c); start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic store(input int a, input int d);
        MemWrite = 1'b1; DataAdr = 32'(a); WriteData = 32'(d);
        step();
        MemWrite = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %0b want 0", o_busy); end
        n_cmp++; if (o_done !== 1'b0) begin n_bad++; $display("FAIL rst_done got %0b want 0", o_done); end
        n_cmp++; if (o_fail_code !== 2'd0) begin n_bad++; $display("FAIL rst_code got %0d want 0", o_fail_code); end
        n_cmp++; if (o_fail_addr !== 32'd0) begin n_bad++; $display("FAIL rst_faddr got %0d want 0", o_fail_addr); end
        n_cmp++; if (o_cycle_count !== 32'd0) begin n_bad++; $display("FAIL rst_cyc got %0d want 0", o_cycle_count); end
        n_cmp++; if (u_done !== 1'b0) begin n_bad++; $display("FAIL rst_udone got %0b want 0", u_done); end
        #1;
        reset = 1'b1;
    endtask

    task automatic test_ordered_ignore();
        do_reset();
        load(0, 100, 25);
        run(1);
        n_cmp++; if (o_busy !== 1'b1) begin n_bad++; $display("FAIL ign_busy got %0b want 1", o_busy); end
        store(96, 7);
        n_cmp++; if (o_ignore_count !== 16'd1) begin n_bad++; $display("FAIL ign_cnt got %0d want 1", o_ignore_count); end
        n_cmp++; if (o_pass !== 1'b0) begin n_bad++; $display("FAIL ign_early_pass got %0b want 0", o_pass); end
        store(100, 25);
        n_cmp++; if (o_pass !== 1'b1) begin n_bad++; $display("FAIL ign_pass got %0b want 1", o_pass); end
        n_cmp++; if (o_done !== 1'b1) begin n_bad++; $display("FAIL ign_done got %0b want 1", o_done); end
        n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL ign_busy2 got %0b want 0", o_busy); end
        n_cmp++; if (o_match_count !== 3'd1) begin n_bad++; $display("FAIL ign_match got %0d want 1", o_match_count); end
        n_cmp++; if (o_cycle_count !== 32'd2) begin n_bad++; $display("FAIL ign_cyc got %0d want 2", o_cycle_count); end
        // frozen in PASS, start ignored
        run(1);
        step();
        n_cmp++; if (o_pass !== 1'b1) begin n_bad++; $display("FAIL hold_pass got %0b want 1", o_pass); end
        n_cmp++; if (o_cycle_count !== 32'd2) begin n_bad++; $display("FAIL hold_cyc got %0d want 2", o_cycle_count); end
        clear = 1'b1; step(); clear = 1'b0;
        n_cmp++; if (o_done !== 1'b0) begin n_bad++; $display("FAIL clr_done got %0b want 0", o_done); end
        n_cmp++; if (o_match_count !== 3'd1) begin n_bad++; $display("FAIL clr_match got %0d want 1", o_match_count); end
        n_cmp++; if (o_ignore_count !== 16'd1) begin n_bad++; $display("FAIL clr_ign got %0d want 1", o_ignore_count); end
        // ignore address present in the table is still skipped
        do_reset();
        load(0, 96, 1);
        run(1);
        store(96, 1);
        n_cmp++; if (o_busy !== 1'b1) begin n_bad++; $display("FAIL igntbl_busy got %0b want 1", o_busy); end
        n_cmp++; if (o_match_count !== 3'd0) begin n_bad++; $display("FAIL igntbl_match got %0d want 0", o_match_count); end
    endtask

    task automatic test_ordered_fail();
        do_reset();
        load(0, 100, 25); load(1, 104, 3);
        run(2);
        store(104, 3);
        n_cmp++; if (o_fail !== 1'b1) begin n_bad++; $display("FAIL ofa_fail got %0b want 1", o_fail); end
        n_cmp++; if (o_fail_code !== 2'd1) begin n_bad++; $display("FAIL ofa_code got %0d want 1", o_fail_code); end
        n_cmp++; if (o_fail_addr !== 32'd104) begin n_bad++; $display("FAIL ofa_addr got %0d want 104", o_fail_addr); end
        n_cmp++; if (o_fail_data !== 32'd3) begin n_bad++; $display("FAIL ofa_data got %0d want 3", o_fail_data); end
        clear = 1'b1; step(); clear = 1'b0;
        n_cmp++; if (o_fail_code !== 2'd0) begin n_bad++; $display("FAIL ofa_clrcode got %0d want 0", o_fail_code); end
        n_cmp++; if (o_fail_addr !== 32'd0) begin n_bad++; $display("FAIL ofa_clraddr got %0d want 0", o_fail_addr); end
        run(2);
        store(100, 25);
        store(104, 4);
        n_cmp++; if (o_fail_code !== 2'd2) begin n_bad++; $display("FAIL ofd_code got %0d want 2", o_fail_code); end
        n_cmp++; if (o_fail_data !== 32'd4) begin n_bad++; $display("FAIL ofd_data got %0d want 4", o_fail_data); end
        n_cmp++; if (o_match_count !== 3'd1) begin n_bad++; $display("FAIL ofd_match got %0d want 1", o_match_count); end
        clear = 1'b1; step(); clear = 1'b0;
        run(2);
        store(100, 25);
        store(104, 3);
        n_cmp++; if (o_pass !== 1'b1) begin n_bad++; $display("FAIL opass_pass got %0b want 1", o_pass); end
        n_cmp++; if (o_match_count !== 3'd2) begin n_bad++; $display("FAIL opass_match got %0d want 2", o_match_count); end
    endtask

    task automatic test_unordered();
        do_reset();
        load(0, 100, 25); load(1, 104, 3);
        run(2);
        store(104, 3);
        n_cmp++; if (u_busy !== 1'b1) begin n_bad++; $display("FAIL ud_busy got %0b want 1", u_busy); end
        store(100, 26);
        n_cmp++; if (u_fail_code !== 2'd2) begin n_bad++; $display("FAIL ud_code got %0d want 2", u_fail_code); end
        n_cmp++; if (u_fail_addr !== 32'd100) begin n_bad++; $display("FAIL ud_addr got %0d want 100", u_fail_addr); end
        n_cmp++; if (u_fail_data !== 32'd26) begin n_bad++; $display("FAIL ud_data got %0d want 26", u_fail_data); end
        n_cmp++; if (u_match_count !== 3'd1) begin n_bad++; $display("FAIL ud_match got %0d want 1", u_match_count); end
        clear = 1'b1; step(); clear = 1'b0;
        run(2);
        store(104, 3);
        store(104, 3);
        n_cmp++; if (u_fail_code !== 2'd1) begin n_bad++; $display("FAIL urep_code got %0d want 1", u_fail_code); end
        n_cmp++; if (u_fail_addr !== 32'd104) begin n_bad++; $display("FAIL urep_addr got %0d want 104", u_fail_addr); end
        clear = 1'b1; step(); clear = 1'b0;
        run(2);
        store(104, 3);
        store(100, 25);
        n_cmp++; if (u_pass !== 1'b1) begin n_bad++; $display("FAIL uany_pass got %0b want 1", u_pass); end
        // duplicate entries each need their own store
        do_reset();
        load(0, 100, 5); load(1, 100, 5);
        run(2);
        store(100, 5);
        n_cmp++; if (u_busy !== 1'b1) begin n_bad++; $display("FAIL udup_busy got %0b want 1", u_busy); end
        store(100, 5);
        n_cmp++; if (u_pass !== 1'b1) begin n_bad++; $display("FAIL udup_pass got %0b want 1", u_pass); end
        // oversized count clamps to the full table
        do_reset();
        load(0, 200, 1); load(1, 204, 2); load(2, 208, 3); load(3, 212, 4);
        run(7);
        store(212, 4); store(200, 1); store(208, 3);
        n_cmp++; if (u_match_count !== 3'd3) begin n_bad++; $display("FAIL uclamp_match got %0d want 3", u_match_count); end
        n_cmp++; if (u_busy !== 1'b1) begin n_bad++; $display("FAIL uclamp_busy got %0b want 1", u_busy); end
        store(204, 2);
        n_cmp++; if (u_pass !== 1'b1) begin n_bad++; $display("FAIL uclamp_pass got %0b want 1", u_pass); end
        n_cmp++; if (u_match_count !== 3'd4) begin n_bad++; $display("FAIL uclamp_match4 got %0d want 4", u_match_count); end
    endtask

    task automatic test_timeout();
        do_reset();
        load(0, 100, 25);
        run(1);
        for (int i = 0; i < 19; i++) step();
        n_cmp++; if (o_busy !== 1'b1) begin n_bad++; $display("FAIL to_busy19 got %0b want 1", o_busy); end
        n_cmp++; if (o_cycle_count !== 32'd19) begin n_bad++; $display("FAIL to_cyc19 got %0d want 19", o_cycle_count); end
        step();
        n_cmp++; if (o_fail_code !== 2'd3) begin n_bad++; $display("FAIL to_code got %0d want 3", o_fail_code); end
        n_cmp++; if (o_cycle_count !== 32'd20) begin n_bad++; $display("FAIL to_cyc got %0d want 20", o_cycle_count); end
        n_cmp++; if (o_fail_addr !== 32'd0) begin n_bad++; $display("FAIL to_addr got %0d want 0", o_fail_addr); end
        clear = 1'b1; step(); clear = 1'b0;
        run(1);
        for (int i = 0; i < 19; i++) step();
        store(100, 25);
        n_cmp++; if (o_pass !== 1'b1) begin n_bad++; $display("FAIL tolast_pass got %0b want 1", o_pass); end
        n_cmp++; if (o_cycle_count !== 32'd20) begin n_bad++; $display("FAIL tolast_cyc got %0d want 20", o_cycle_count); end
        clear = 1'b1; step(); clear = 1'b0;
        run(1);
        for (int i = 0; i < 19; i++) step();
        store(104, 9);
        n_cmp++; if (o_fail_code !== 2'd1) begin n_bad++; $display("FAIL tobad_code got %0d want 1", o_fail_code); end
        n_cmp++; if (o_fail_addr !== 32'd104) begin n_bad++; $display("FAIL tobad_addr got %0d want 104", o_fail_addr); end
    endtask

    task automatic test_start_corners();
        do_reset();
        run(0);
        n_cmp++; if (o_pass !== 1'b1) begin n_bad++; $display("FAIL zero_pass got %0b want 1", o_pass); end
        n_cmp++; if (u_pass !== 1'b1) begin n_bad++; $display("FAIL zero_upass got %0b want 1", u_pass); end
        n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL zero_busy got %0b want 0", o_busy); end
        // table write and start on the same edge; later writes in RUN dropped
        do_reset();
        exp_we = 1'b1; exp_idx = 2'd0; exp_addr = 32'd300; exp_data = 32'd9;
        exp_count = 3'd1; start = 1'b1;
        step();
        exp_we = 1'b0; start = 1'b0;
        n_cmp++; if (o_busy !== 1'b1) begin n_bad++; $display("FAIL same_busy got %0b want 1", o_busy); end
        load(0, 400, 1);
        store(300, 9);
        n_cmp++; if (o_pass !== 1'b1) begin n_bad++; $display("FAIL same_pass got %0b want 1", o_pass); end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        load(0, 100, 25); load(1, 104, 3);
        run(2);
        store(100, 25);
        n_cmp++; if (o_match_count !== 3'd1) begin n_bad++; $display("FAIL mid_match1 got %0d want 1", o_match_count); end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy got %0b want 0", o_busy); end
        n_cmp++; if (o_match_count !== 3'd0) begin n_bad++; $display("FAIL mid_match got %0d want 0", o_match_count); end
        n_cmp++; if (o_cycle_count !== 32'd0) begin n_bad++; $display("FAIL mid_cyc got %0d want 0", o_cycle_count); end
        #1;
        reset = 1'b1;
        run(1);
        n_cmp++; if (o_busy !== 1'b1) begin n_bad++; $display("FAIL mid_rerun got %0b want 1", o_busy); end
        store(0, 0);
        n_cmp++; if (o_pass !== 1'b1) begin n_bad++; $display("FAIL mid_tblclr got %0b want 1", o_pass); end
    endtask

    initial begin
        test_reset();
        test_ordered_ignore();
        test_ordered_fail();
        test_unordered();
        test_timeout();
        test_start_corners();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_write_checker.md
Name: mem_write_checker

Overview:
- Synthesizable self-checking monitor on the core's data-memory write port (MemWrite/DataAdr/WriteData), instantiated beside top in the benches and optionally on FPGA.
- Compares observed stores against a programmable table of up to NUM_EXP expected (address, data) pairs, in ordered or unordered mode.
- Skips one configurable scratch address, enforces a cycle timeout, and reports pass/fail with diagnostic capture.

Parameters:
- XLEN, 32, address/data width
- NUM_EXP, 4, expected-table depth (>=1)
- ORDERED, 1, 1 = expected writes must occur in table order; 0 = any order
- IGNORE_EN, 1, 1 = writes to IGNORE_ADDR are skipped
- IGNORE_ADDR, 96, scratch address excluded from checking
- TIMEOUT_CYCLES, 10000, RUN cycles before timeout failure (>=1)

Ports:
- clk  in  1  clock, rising-edge
- reset  in  1  asynchronous, active-low
- exp_we  in  1  table write strobe (honoured in IDLE only)
- exp_idx  in  $clog2(NUM_EXP) (min 1)  table entry index
- exp_addr  in  XLEN  expected address
- exp_data  in  XLEN  expected data
- exp_count  in  $clog2(NUM_EXP+1)  number of active entries, latched on start
- start  in  1  arm checker (IDLE only)
- clear  in  1  return to IDLE from PASS/FAIL
- MemWrite  in  1  store strobe from core
- DataAdr  in  XLEN  store address
- WriteData  in  XLEN  store data
- busy  out  1  high in RUN
- done  out  1  high in PASS or FAIL
- pass  out  1  high in PASS
- fail  out  1  high in FAIL
- fail_code  out  2  0 none, 1 unexpected address, 2 data mismatch, 3 timeout
- fail_addr  out  XLEN  DataAdr of failing store (0 on timeout)
- fail_data  out  XLEN  WriteData of failing store (0 on timeout)
- match_count  out  $clog2(NUM_EXP+1)  expected writes matched so far
- ignore_count  out  16  ignored writes, saturating at 0xFFFF
- cycle_count  out  32  RUN cycles elapsed

Behaviour:
- Reset (reset=0, async):
  - state IDLE; every output 0.
  - Table contents, hit bits and latched count cleared to 0.
- FSM states IDLE, RUN, PASS, FAIL; all outputs registered.
- IDLE:
  - exp_we writes entry exp_idx on the edge.
  - start: latch exp_count (values >NUM_EXP clamp to NUM_EXP); clear hit bits, pointer and all counters; go to RUN.
  - If latched count = 0, go directly to PASS instead.
  - exp_we and start in the same cycle: table write lands first, then start.
- RUN: cycle_count increments every cycle. MemWrite is sampled on the rising edge; stores outside RUN are ignored.
  - Ignore rule: IGNORE_EN=1 and DataAdr==IGNORE_ADDR → ignore_count+1 and no compare, even if IGNORE_ADDR is in the table.
  - Ordered mode: compare against entry[ptr].
    - Address and data equal → hit, ptr+1.
    - Address differs → FAIL code 1.
    - Address equal, data differs → FAIL code 2.
  - Unordered mode: search unhit active entries with address equal.
    - One with equal data → set its hit bit (lowest index wins on duplicates).
    - Address match only, with differing data → FAIL code 2.
    - No unhit address match, including a repeat write to an already-hit entry → FAIL code 1.
  - match_count increments on each hit. When it reaches the latched count → PASS.
  - Timeout: cycle_count == TIMEOUT_CYCLES-1 with no completing hit → FAIL code 3.
  - A hit completing the table on the timeout cycle → PASS (store wins). A failing store on the timeout cycle → its store code, not 3.
- Latency: busy/pass/fail/fail_code/fail_addr/fail_data/counters take the new value the cycle after the deciding edge.
- PASS/FAIL:
  - Hold all outputs and counters frozen; start ignored.
  - clear → IDLE, done/pass/fail/fail_code/fail_* to 0. Counters keep values until next start.
- clear in IDLE/RUN ignored; exp_we outside IDLE ignored.
- Async reset mid-RUN aborts immediately to reset state.

Decomposition:
- Package mwc_pkg holds:
  - state enum: IDLE, RUN, PASS, FAIL
  - fail-code enum: FC_NONE, FC_ADDR, FC_DATA, FC_TIMEOUT
  - typedef exp_entry_t {addr, data}
- Sub-module mwc_exp_table: entry storage, hit bits, and combinational match lookup returning hit-valid, index, addr-only-match and ptr-compare results.
- mem_write_checker contains the FSM, counters and capture registers.

Test Plan:
- Ordered, count=1, entry0=(100,25); stores (96,7) then (100,25) → ignore_count=1, pass=1 the cycle after the second store, match_count=1.
- Ordered, entries (100,25),(104,3); store (104,3) first → fail=1, fail_code=1, fail_addr=104, fail_data=3.
- Unordered, entries (100,25),(104,3); stores (104,3),(100,26) → fail_code=2, fail_addr=100, fail_data=26, match_count=1.
- Unordered, same table; store (104,3) twice → fail_code=1 on the second store.
- TIMEOUT_CYCLES=20, count=1, no stores → fail_code=3 with cycle_count=20; separately, the completing store on cycle 19 → pass.
- count=0 start → pass next cycle. Reset asserted mid-RUN after one hit → all outputs 0 asynchronously, state IDLE, table cleared.
